counter_gen: RTL and testbench
==============================

# counter_gen

Parametrised, prescaled up/down counter; next generation of the design's free-running 32-bit counter. Adds enable, clock-enable prescaler, synchronous clear/load, programmable terminal limit, wrap or saturate mode, terminal-count pulse and sticky overflow flag. Sits in the Hardware/DUT partition as a general event/time-base counter feeding timers and status logic.

## Interface
Parameters:
- `WIDTH`, 32, counter and limit width (2..64)
- `PRE_W`, 8, prescaler width (1..16)

Ports:
- `clk`  in  1  sole clock, posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable; prescaler advances only when high
- `clr`  in  1  synchronous clear of count, prescaler, `ovf`
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  WIDTH  value for load
- `up_dn`  in  1  1 = count up, 0 = count down
- `sat`  in  1  1 = saturate at terminal, 0 = wrap
- `limit`  in  WIDTH  terminal value for up-count, reload value for down-wrap
- `prescale`  in  PRE_W  tick every `prescale`+1 enabled cycles
- `cap_stb`  in  1  capture strobe (see Configuration)
- `out`  out  WIDTH  current count (registered)
- `tc`  out  1  one-cycle terminal-count pulse (registered)
- `ovf`  out  1  sticky: set by any `tc`, cleared by `clr`
- `cap_val`  out  WIDTH  captured count

## Operation
- Prescaler `pre_cnt` (PRE_W bits): when `en`=1, tick = (`pre_cnt`==`prescale`); on tick `pre_cnt`←0, else `pre_cnt`+1. `en`=0 holds `pre_cnt`, no tick. `prescale`=0 → tick every enabled cycle.
- Priority per edge: `clr` > `load` > tick. `clr`: `out`←0, `pre_cnt`←0, `ovf`←0, `tc`←0. `load`: `out`←`load_val`, `pre_cnt`←0, `tc`←0, `ovf` unchanged.
- Terminal: up: `out` ≥ `limit` (unsigned); down: `out` == 0.
- On tick, not terminal: `out`±1.
- On tick, terminal: `tc`←1, `ovf`←1; wrap: up → 0, down → `limit`; saturate: `out` held.
- `tc` is 1 only on the cycle after a terminal tick; 0 otherwise. Saturate mode pulses `tc` on every tick spent at terminal.
- `limit`, `up_dn`, `sat`, `prescale` sampled every edge; changes take effect on the next tick, no restart.
- Loaded value above `limit` in up mode: next tick is terminal (wrap to 0 / hold).
- Arithmetic modulo 2^WIDTH; `limit`=0 up-wrap gives `tc` on every tick with `out` fixed at 0.

## Timing
- Reset (async assert, sync-to-`clk` deassert inside block): `out`=0, `tc`=0, `ovf`=0, `cap_val`=0, `pre_cnt`=0.
- Reset asserted mid-count: all state cleared immediately, no `tc`.
- Latency: tick at edge N → `out`, `tc`, `ovf` updated at edge N, visible cycle N+1.
- `prescale`=P, `en` constant 1 from reset: first increment visible after P+1 edges.
- `clr` and `load` same cycle: clear wins; `load` with `en`/tick same cycle: load wins, tick discarded.

## Configuration
- `COUNTER_GEN_CAPTURE_EN` defined: on edge with `cap_stb`=1, `cap_val`←`out` value before that edge's update; holds otherwise; `clr` does not affect `cap_val`.
- Not defined: capture register omitted, `cap_val` tied 0, `cap_stb` ignored.

## Test plan
- Reset, WIDTH=32, `en`=1, `prescale`=0, up, wrap, `limit`=5 → `out` 0,1,2,3,4,5,0; `tc` high exactly with the 5→0 transition; `ovf`=1 thereafter.
- `prescale`=3, `limit`=0xFFFFFFFF → `out` increments every 4th cycle; `en` low 10 cycles freezes `out` and prescaler phase.
- Down, saturate, `load_val`=2 → 2,1,0,0,0; `tc` pulses on each tick at 0; `sat`→0 next tick gives `out`=`limit`.
- `load_val`=10, `limit`=5, up, wrap → next tick `out`=0, `tc`=1; `clr`+`load` same edge → `out`=0, `ovf`=0.
- `rst_n` dropped mid-count at `out`=3 → all outputs 0 asynchronously; counting resumes from 0 after release.
- With `COUNTER_GEN_CAPTURE_EN`: `cap_stb` on edge where `out`=7 → `cap_val`=7 while `out`=8; without macro `cap_val` stays 0.

Source files
------------

// File: rtl/counter_gen.sv
// Prescaled up/down event/time-base counter: clear/load, programmable limit, wrap or saturate,
// terminal-count pulse, sticky overflow. Optional capture register under COUNTER_GEN_CAPTURE_EN.
module counter_gen #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic             cap_stb,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] cap_val
);

  // Reset asserts asynchronously, releases two edges after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};

  assign rst_i = rst_sync[1];

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             term;

  assign tick = en && (pre_cnt == prescale);
  assign term = up_dn ? (out >= limit) : (out == '0);

  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      out     <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else if (clr) begin
      out     <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      // A tick landing on the load edge is discarded.
      out     <= load_val;
      pre_cnt <= '0;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (en) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        if (term) begin
          tc  <= 1'b1;
          ovf <= 1'b1;
          if (!sat) out <= up_dn ? '0 : limit;
        end else begin
          out <= up_dn ? out + 1'b1 : out - 1'b1;
        end
      end
    end

`ifdef COUNTER_GEN_CAPTURE_EN
  // Captures the pre-update count; clr intentionally leaves it alone.
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i)       cap_val <= '0;
    else if (cap_stb) cap_val <= out;
`else
  logic unused_cap;
  assign unused_cap = cap_stb;
  assign cap_val    = '0;
`endif

endmodule

// File: tb/tb_counter_gen.sv
// Directed bench for counter_gen: rule-level reference model checked every cycle,
// plus literal expectations for the headline sequences.
module tb_counter_gen;
  localparam int W  = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr, load, up_dn, sat, cap_stb;
  logic [W-1:0]  load_val, limit;
  logic [PW-1:0] prescale;
  logic [W-1:0]  out, cap_val;
  logic          tc, ovf;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  counter_gen #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .sat(sat), .limit(limit), .prescale(prescale), .cap_stb(cap_stb),
    .out(out), .tc(tc), .ovf(ovf), .cap_val(cap_val)
  );

  always #5 clk = ~clk;

  // Reference model: prescaler as a count of enabled cycles since the last tick/clear/load.
  logic [W-1:0]  m_out, m_cap;
  logic          m_tc, m_ovf;
  int unsigned   m_since;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= '0; m_cap <= '0; m_tc <= 1'b0; m_ovf <= 1'b0; m_since <= 0;
    end else begin
`ifdef COUNTER_GEN_CAPTURE_EN
      if (cap_stb) m_cap <= m_out;
`endif
      m_tc <= 1'b0;
      if (clr) begin
        m_out <= '0; m_ovf <= 1'b0; m_since <= 0;
      end else if (load) begin
        m_out <= load_val; m_since <= 0;
      end else if (en) begin
        if (m_since < int'(prescale)) m_since <= m_since + 1;
        else begin
          m_since <= 0;
          if (up_dn ? (m_out >= limit) : (m_out == 0)) begin
            m_tc <= 1'b1; m_ovf <= 1'b1;
            if (!sat) m_out <= up_dn ? W'(0) : limit;
          end else begin
            m_out <= up_dn ? W'(m_out + 1) : W'(m_out - 1);
          end
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    total++;
    if (out !== m_out || tc !== m_tc || ovf !== m_ovf || cap_val !== m_cap) begin
      bad++;
      $display("FAIL model cyc: out=%0h/%0h tc=%0b/%0b ovf=%0b/%0b cap=%0h/%0h (dut/model)",
               out, m_out, tc, m_tc, ovf, m_ovf, cap_val, m_cap);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [W-1:0] seq_out [7];
  logic         seq_tc  [7];

  initial begin
    seq_out = '{1, 2, 3, 4, 5, 0, 1};
    seq_tc  = '{0, 0, 0, 0, 0, 1, 0};
    rst_n = 1'b0; en = 0; clr = 0; load = 0; up_dn = 1; sat = 0; cap_stb = 0;
    load_val = '0; limit = 5; prescale = '0;
    go(2);
    chk("reset out", out, 0); chk("reset tc", W'(tc), 0);
    chk("reset ovf", W'(ovf), 0); chk("reset cap", cap_val, 0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    go(3);

    // Up, wrap, limit 5
    en = 1;
    for (int i = 0; i < 7; i++) begin
      go(1);
      chk("wrap5 out", out, seq_out[i]);
      chk("wrap5 tc", W'(tc), W'(seq_tc[i]));
    end
    chk("wrap5 ovf", W'(ovf), 1);

    // Prescale 3, en freeze
    clr = 1; go(1); clr = 0;
    prescale = 3; limit = '1;
    go(3); chk("pre3 hold", out, 0);
    go(1); chk("pre3 first", out, 1);
    go(4); chk("pre3 second", out, 2);
    go(2);
    en = 0; go(10); chk("freeze", out, 2);
    en = 1; go(1); chk("phase kept a", out, 2);
    go(1); chk("phase kept b", out, 3);

    // Down, saturate
    up_dn = 0; sat = 1; limit = 9; prescale = 0; load = 1; load_val = 2;
    go(1); load = 0; chk("load 2", out, 2);
    go(1); chk("dn 1", out, 1);
    go(1); chk("dn 0", out, 0); chk("dn tc0", W'(tc), 0);
    go(1); chk("sat hold", out, 0); chk("sat tc a", W'(tc), 1);
    go(1); chk("sat hold b", out, 0); chk("sat tc b", W'(tc), 1);
    sat = 0;
    go(1); chk("dn wrap", out, 9); chk("dn wrap tc", W'(tc), 1);

    // Load above limit, then clr+load together
    up_dn = 1; limit = 5; load = 1; load_val = 10;
    go(1); load = 0; chk("load 10", out, 10);
    go(1); chk("over wrap", out, 0); chk("over tc", W'(tc), 1);
    clr = 1; load = 1;
    go(1); clr = 0; load = 0;
    chk("clr wins out", out, 0); chk("clr wins ovf", W'(ovf), 0);

    // limit 0 up-wrap: tc every tick, out stuck at 0
    limit = 0;
    go(1); chk("lim0 out", out, 0); chk("lim0 tc", W'(tc), 1);
    go(1); chk("lim0 tc b", W'(tc), 1);

    // Async reset mid-count
    clr = 1; go(1); clr = 0; limit = 100;
    go(3); chk("pre rst", out, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out", out, 0); chk("arst tc", W'(tc), 0); chk("arst ovf", W'(ovf), 0);
    en = 0;
    go(1); rst_n = 1'b1;
    go(3); en = 1;
    go(2); chk("resume", out, 2);

    // Capture
    clr = 1; go(1); clr = 0;
    go(7); chk("pre cap", out, 7);
    cap_stb = 1; go(1); cap_stb = 0;
    chk("cap out", out, 8);
`ifdef COUNTER_GEN_CAPTURE_EN
    chk("cap val", cap_val, 7);
    go(2); chk("cap held", cap_val, 7);
`else
    chk("cap val", cap_val, 0);
    go(2); chk("cap held", cap_val, 0);
`endif

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
